// File: rtl/mk_design_pipe.sv
// mk_design_pipe: queued sum/abs-difference pipeline with offset result, consuming check and mismatch counter
module mk_design_pipe #(
  parameter int WIDTH = 6,
  parameter int DEPTH = 4,
  parameter int MODE  = 0
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [WIDTH-1:0] variable_a,
  input  logic [WIDTH-1:0] variable_b,
  input  logic             EN_start,
  output logic             RDY_start,
  input  logic [WIDTH:0]   variable_c,
  output logic [WIDTH:0]   result,
  output logic             RDY_result,
  input  logic [WIDTH-1:0] variable_d,
  input  logic             EN_check,
  output logic             check,
  output logic             RDY_check,
  output logic [15:0]      mismatches
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] ONE = 1;

  logic [2*WIDTH-1:0] iq_q [DEPTH];
  logic [WIDTH:0]     oq_q [DEPTH];
  logic [AW:0]        iwp_q, irp_q, owp_q, orp_q;
  logic [AW:0]        iwp_d, irp_d, owp_d, orp_d;
  logic               cr_v_q, cr_v_d;
  logic [WIDTH:0]     cr_q, cr_d;
  logic [15:0]        mism_q, mism_d;
  logic               iq_empty, iq_full, oq_empty, oq_full;
  logic               fire_s, fire_c, drain, adv;
  logic [WIDTH-1:0]   in_a, in_b;
  logic [WIDTH:0]     head, f_v;

  // queue status, method outputs and the operation applied to the in-queue head
  always_comb begin
    iq_empty   = iwp_q == irp_q;
    iq_full    = (iwp_q[AW] != irp_q[AW]) && (iwp_q[AW-1:0] == irp_q[AW-1:0]);
    oq_empty   = owp_q == orp_q;
    oq_full    = (owp_q[AW] != orp_q[AW]) && (owp_q[AW-1:0] == orp_q[AW-1:0]);
    RDY_start  = !iq_full;
    RDY_result = !oq_empty;
    RDY_check  = !oq_empty;
    head       = oq_q[orp_q[AW-1:0]];
    result     = oq_empty ? '0 : head + variable_c;
    check      = !oq_empty && (head[WIDTH-1:0] == variable_d);
    {in_a, in_b} = iq_q[irp_q[AW-1:0]];
    f_v        = (MODE != 0) ? ((in_a >= in_b) ? {1'b0, in_a - in_b} : {1'b0, in_b - in_a})
                             : {1'b0, in_a} + {1'b0, in_b};
  end

  // handshakes and next state; a check firing frees an out-queue slot for the drain on the same edge
  always_comb begin
    fire_s = EN_start && RDY_start;
    fire_c = EN_check && RDY_check;
    drain  = cr_v_q && (!oq_full || fire_c);
    adv    = !iq_empty && (!cr_v_q || drain);
    iwp_d  = fire_s ? iwp_q + ONE : iwp_q;
    irp_d  = adv ? irp_q + ONE : irp_q;
    owp_d  = drain ? owp_q + ONE : owp_q;
    orp_d  = fire_c ? orp_q + ONE : orp_q;
    cr_v_d = adv ? 1'b1 : (drain ? 1'b0 : cr_v_q);
    cr_d   = adv ? f_v : cr_q;
    mism_d = (fire_c && !check && mism_q != 16'hFFFF) ? mism_q + 16'd1 : mism_q;
  end

  // control state with synchronous reset
  always_ff @(posedge CLK) begin
    if (RST) begin
      iwp_q  <= '0;
      irp_q  <= '0;
      owp_q  <= '0;
      orp_q  <= '0;
      cr_v_q <= 1'b0;
      cr_q   <= '0;
      mism_q <= '0;
    end else begin
      iwp_q  <= iwp_d;
      irp_q  <= irp_d;
      owp_q  <= owp_d;
      orp_q  <= orp_d;
      cr_v_q <= cr_v_d;
      cr_q   <= cr_d;
      mism_q <= mism_d;
    end
  end

  // queue storage needs no reset; pointers alone decide what is visible
  always_ff @(posedge CLK) begin
    if (fire_s) iq_q[iwp_q[AW-1:0]] <= {variable_a, variable_b};
    if (drain) oq_q[owp_q[AW-1:0]] <= cr_q;
  end

  assign mismatches = mism_q;
endmodule

// File: tb/tb_mk_design_pipe.sv
// tb_mk_design_pipe: randomized and directed bench for both operation modes against a queue-based model
module tb_mk_design_pipe;
  localparam int W = 6;
  localparam int D = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic           rst = 1'b1, en_s = 1'b0, en_c = 1'b0;
  logic [W-1:0]   va = '0, vb = '0, vd = '0;
  logic [W:0]     vc = '0;
  logic           rdy_s [2], rdy_r [2], rdy_c [2], chk [2];
  logic [W:0]     res [2];
  logic [15:0]    mis [2];

  int checks = 0, errors = 0;

  mk_design_pipe #(.WIDTH(W), .DEPTH(D), .MODE(0)) dut0 (
    .CLK(clk), .RST(rst), .variable_a(va), .variable_b(vb), .EN_start(en_s), .RDY_start(rdy_s[0]),
    .variable_c(vc), .result(res[0]), .RDY_result(rdy_r[0]), .variable_d(vd), .EN_check(en_c),
    .check(chk[0]), .RDY_check(rdy_c[0]), .mismatches(mis[0]));

  mk_design_pipe #(.WIDTH(W), .DEPTH(D), .MODE(1)) dut1 (
    .CLK(clk), .RST(rst), .variable_a(va), .variable_b(vb), .EN_start(en_s), .RDY_start(rdy_s[1]),
    .variable_c(vc), .result(res[1]), .RDY_result(rdy_r[1]), .variable_d(vd), .EN_check(en_c),
    .check(chk[1]), .RDY_check(rdy_c[1]), .mismatches(mis[1]));

  // model: operand pairs flow through queues; the mode only changes what the head evaluates to
  logic [2*W-1:0] iq [$];
  logic [2*W-1:0] oq [$];
  logic [2*W-1:0] crp;
  bit             crv;
  int             mm [2];
  bit             fs, fc, dr, ad;

  function automatic int fm(int m, logic [2*W-1:0] p);
    int a = int'(p[2*W-1:W]);
    int b = int'(p[W-1:0]);
    return (m == 1) ? ((a > b) ? a - b : b - a) : a + b;
  endfunction

  function automatic int e_res(int m);
    return (oq.size() == 0) ? 0 : (fm(m, oq[0]) + int'(vc)) % (2 ** (W + 1));
  endfunction

  function automatic bit e_chk(int m);
    return oq.size() > 0 && (fm(m, oq[0]) % (2 ** W)) == int'(vd);
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      iq.delete();
      oq.delete();
      crv = 1'b0;
      mm = '{0, 0};
    end else begin
      fs = en_s && iq.size() < D;
      fc = en_c && oq.size() > 0;
      dr = crv && (oq.size() < D || fc);
      ad = iq.size() > 0 && (!crv || dr);
      if (fc) begin
        for (int m = 0; m < 2; m++) if (!e_chk(m) && mm[m] < 65535) mm[m]++;
        void'(oq.pop_front());
      end
      if (dr) oq.push_back(crp);
      if (ad) begin
        crp = iq.pop_front();
        crv = 1'b1;
      end else if (dr) crv = 1'b0;
      if (fs) iq.push_back({va, vb});
    end
  end

  task automatic drive(input logic r, input logic s, input int a, input int b, input int c, input int d, input logic k);
    @(negedge clk);
    rst = r; en_s = s; va = W'(a); vb = W'(b); vc = (W+1)'(c); vd = W'(d); en_c = k;
    #1;
  endtask

  task automatic test_reset;
    drive(1, 1, 7, 7, 0, 0, 1);
    drive(1, 1, 7, 7, 0, 0, 1);
    drive(0, 0, 0, 0, 5, 0, 0);
    for (int m = 0; m < 2; m++) begin
      checks++; if (rdy_s[m] !== 1'b1) begin errors++; $display("FAIL reset_rdy_start m=%0d got %b exp 1", m, rdy_s[m]); end
      checks++; if (rdy_r[m] !== 1'b0) begin errors++; $display("FAIL reset_rdy_result m=%0d got %b exp 0", m, rdy_r[m]); end
      checks++; if (rdy_c[m] !== 1'b0) begin errors++; $display("FAIL reset_rdy_check m=%0d got %b exp 0", m, rdy_c[m]); end
      checks++; if (res[m] !== '0) begin errors++; $display("FAIL reset_result m=%0d got %0d exp 0", m, res[m]); end
      checks++; if (chk[m] !== 1'b0) begin errors++; $display("FAIL reset_check m=%0d got %b exp 0", m, chk[m]); end
      checks++; if (mis[m] !== 16'd0) begin errors++; $display("FAIL reset_mismatches m=%0d got %0d exp 0", m, mis[m]); end
    end
  endtask

  task automatic test_basic;
    drive(0, 1, 5, 9, 0, 0, 0);
    drive(0, 0, 0, 0, 0, 0, 0);
    checks++; if (rdy_r[0] !== 1'b0) begin errors++; $display("FAIL basic_rdy_t1 got %b exp 0", rdy_r[0]); end
    drive(0, 0, 0, 0, 0, 0, 0);
    checks++; if (rdy_r[0] !== 1'b0) begin errors++; $display("FAIL basic_rdy_t2 got %b exp 0", rdy_r[0]); end
    drive(0, 0, 0, 0, 1, 14, 1);
    checks++; if (rdy_r[0] !== 1'b1) begin errors++; $display("FAIL basic_rdy_t3 got %b exp 1", rdy_r[0]); end
    checks++; if (res[0] !== 7'd15) begin errors++; $display("FAIL basic_result got %0d exp 15", res[0]); end
    checks++; if (chk[0] !== 1'b1) begin errors++; $display("FAIL basic_check got %b exp 1", chk[0]); end
    checks++; if (res[1] !== (W+1)'(e_res(1))) begin errors++; $display("FAIL basic_result_m1 got %0d exp %0d", res[1], e_res(1)); end
    checks++; if (chk[1] !== e_chk(1)) begin errors++; $display("FAIL basic_check_m1 got %b exp %b", chk[1], e_chk(1)); end
    drive(0, 0, 0, 0, 0, 0, 0);
    checks++; if (rdy_r[0] !== 1'b0) begin errors++; $display("FAIL basic_rdy_after got %b exp 0", rdy_r[0]); end
    checks++; if (mis[0] !== 16'd0) begin errors++; $display("FAIL basic_mismatches got %0d exp 0", mis[0]); end
    checks++; if (mis[1] !== 16'(mm[1])) begin errors++; $display("FAIL basic_mismatches_m1 got %0d exp %0d", mis[1], mm[1]); end
  endtask

  task automatic test_wrap;
    drive(0, 1, 63, 63, 0, 0, 0);
    drive(0, 0, 0, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 3, 62, 1);
    checks++; if (res[0] !== 7'd1) begin errors++; $display("FAIL wrap_result got %0d exp 1", res[0]); end
    checks++; if (chk[0] !== 1'b1) begin errors++; $display("FAIL wrap_check got %b exp 1", chk[0]); end
    checks++; if (res[1] !== 7'd3) begin errors++; $display("FAIL wrap_result_m1 got %0d exp 3", res[1]); end
    drive(0, 0, 0, 0, 0, 0, 0);
    checks++; if (rdy_r[0] !== 1'b0) begin errors++; $display("FAIL wrap_rdy_after got %b exp 0", rdy_r[0]); end
  endtask

  task automatic test_backpressure;
    int k = 1;
    for (int i = 0; i < 15; i++) begin
      drive(0, 1, k, 0, 0, 0, 0);
      checks++; if (rdy_s[0] !== (iq.size() < D)) begin errors++; $display("FAIL bp_rdy_start cyc=%0d got %b exp %b", i, rdy_s[0], iq.size() < D); end
      if (rdy_s[0] === 1'b1) k++;
    end
    checks++; if (k - 1 != 9) begin errors++; $display("FAIL bp_accepted got %0d exp 9", k - 1); end
    for (int i = 1; i <= 9; i++) begin
      drive(0, 0, 0, 0, 0, i, 1);
      for (int m = 0; m < 2; m++) begin
        checks++; if (rdy_r[m] !== 1'b1) begin errors++; $display("FAIL bp_rdy_result m=%0d i=%0d got %b exp 1", m, i, rdy_r[m]); end
        checks++; if (res[m] !== (W+1)'(i)) begin errors++; $display("FAIL bp_order m=%0d got %0d exp %0d", m, res[m], i); end
        checks++; if (chk[m] !== 1'b1) begin errors++; $display("FAIL bp_check m=%0d i=%0d got %b exp 1", m, i, chk[m]); end
      end
      if (i == 1) begin
        checks++; if (rdy_s[0] !== 1'b0) begin errors++; $display("FAIL bp_rdy_before_pop got %b exp 0", rdy_s[0]); end
      end
      if (i == 2) begin
        checks++; if (rdy_s[0] !== 1'b1) begin errors++; $display("FAIL bp_rdy_reassert got %b exp 1", rdy_s[0]); end
      end
    end
    drive(0, 0, 0, 0, 0, 0, 0);
    checks++; if (rdy_r[0] !== 1'b0) begin errors++; $display("FAIL bp_drained got %b exp 0", rdy_r[0]); end
  endtask

  task automatic test_mode;
    drive(1, 0, 0, 0, 0, 0, 0);
    drive(0, 1, 3, 10, 0, 0, 0);
    drive(0, 0, 0, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 0, 6, 1);
    checks++; if (res[1] !== 7'd7) begin errors++; $display("FAIL mode_head got %0d exp 7", res[1]); end
    checks++; if (chk[1] !== 1'b0) begin errors++; $display("FAIL mode_check got %b exp 0", chk[1]); end
    drive(0, 1, 3, 10, 0, 0, 0);
    checks++; if (mis[1] !== 16'd1) begin errors++; $display("FAIL mode_mismatches1 got %0d exp 1", mis[1]); end
    drive(0, 1, 3, 10, 0, 0, 0);
    drive(0, 1, 3, 10, 0, 0, 0);
    drive(0, 0, 0, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) drive(0, 0, 0, 0, 0, 6, 1);
    drive(0, 0, 0, 0, 0, 0, 0);
    checks++; if (mis[1] !== 16'd4) begin errors++; $display("FAIL mode_mismatches4 got %0d exp 4", mis[1]); end
    checks++; if (mis[0] !== 16'(mm[0])) begin errors++; $display("FAIL mode_mismatches_m0 got %0d exp %0d", mis[0], mm[0]); end
  endtask

  task automatic test_reset_mid;
    drive(0, 1, 1, 2, 0, 0, 0);
    drive(0, 1, 3, 4, 0, 0, 0);
    drive(0, 1, 5, 6, 0, 0, 0);
    drive(1, 1, 7, 8, 0, 0, 1);
    drive(0, 0, 0, 0, 9, 0, 0);
    for (int m = 0; m < 2; m++) begin
      checks++; if (rdy_s[m] !== 1'b1) begin errors++; $display("FAIL mid_rdy_start m=%0d got %b exp 1", m, rdy_s[m]); end
      checks++; if (rdy_r[m] !== 1'b0) begin errors++; $display("FAIL mid_rdy_result m=%0d got %b exp 0", m, rdy_r[m]); end
      checks++; if (res[m] !== '0) begin errors++; $display("FAIL mid_result m=%0d got %0d exp 0", m, res[m]); end
      checks++; if (chk[m] !== 1'b0) begin errors++; $display("FAIL mid_check m=%0d got %b exp 0", m, chk[m]); end
      checks++; if (mis[m] !== 16'd0) begin errors++; $display("FAIL mid_mismatches m=%0d got %0d exp 0", m, mis[m]); end
    end
    drive(0, 0, 0, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 0, 0, 0);
    checks++; if (rdy_r[0] !== 1'b0) begin errors++; $display("FAIL mid_no_start got %b exp 0", rdy_r[0]); end
  endtask

  task automatic test_random;
    for (int i = 0; i < 600; i++) begin
      drive(0, $urandom_range(0, 2) != 0, $urandom_range(0, (i % 2) ? 63 : 7), $urandom_range(0, (i % 2) ? 63 : 7),
            $urandom_range(0, 127), $urandom_range(0, 14), (i % 100 < 50) ? $urandom_range(0, 3) == 0 : $urandom_range(0, 3) != 0);
      for (int m = 0; m < 2; m++) begin
        checks++; if (rdy_s[m] !== (iq.size() < D)) begin errors++; $display("FAIL rnd_rdy_start m=%0d cyc=%0d got %b exp %b", m, i, rdy_s[m], iq.size() < D); end
        checks++; if (rdy_r[m] !== (oq.size() > 0)) begin errors++; $display("FAIL rnd_rdy_result m=%0d cyc=%0d got %b exp %b", m, i, rdy_r[m], oq.size() > 0); end
        checks++; if (rdy_c[m] !== (oq.size() > 0)) begin errors++; $display("FAIL rnd_rdy_check m=%0d cyc=%0d got %b exp %b", m, i, rdy_c[m], oq.size() > 0); end
        checks++; if (res[m] !== (W+1)'(e_res(m))) begin errors++; $display("FAIL rnd_result m=%0d cyc=%0d got %0d exp %0d", m, i, res[m], e_res(m)); end
        checks++; if (chk[m] !== e_chk(m)) begin errors++; $display("FAIL rnd_check m=%0d cyc=%0d got %b exp %b", m, i, chk[m], e_chk(m)); end
        checks++; if (mis[m] !== 16'(mm[m])) begin errors++; $display("FAIL rnd_mismatches m=%0d cyc=%0d got %0d exp %0d", m, i, mis[m], mm[m]); end
      end
    end
  endtask

  initial begin
    test_reset;
    test_basic;
    test_wrap;
    test_backpressure;
    test_mode;
    test_reset_mid;
    test_random;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
